// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two requester ports and the shared memory port.
// master is the arbiter's view; slave is the front ends plus memory.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    logic              i_read;
    logic [ADDR_W-1:0] i_address;
    logic [DATA_W-1:0] i_rdata;
    logic              i_resp;

    logic              d_read;
    logic              d_write;
    logic [BE_W-1:0]   d_byte_enable;
    logic [ADDR_W-1:0] d_address;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_resp;

    logic              mem_read;
    logic              mem_write;
    logic [BE_W-1:0]   mem_byte_enable;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_resp;

    modport master (
        input  i_read, i_address,
        output i_rdata, i_resp,
        input  d_read, d_write, d_byte_enable, d_address, d_wdata,
        output d_rdata, d_resp,
        output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        input  mem_rdata, mem_resp
    );

    modport slave (
        output i_read, i_address,
        input  i_rdata, i_resp,
        output d_read, d_write, d_byte_enable, d_address, d_wdata,
        input  d_rdata, d_resp,
        input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        output mem_rdata, mem_resp
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between I-fetch and load/store.
// One transaction in flight; request fields are latched at grant.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic clk,
    input logic rst,
    mem_port_arbiter_if.master bus
);
    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;

    state_t            state;
    state_t            state_nxt;
    logic              last_d;
    logic              last_d_nxt;
    logic              load_i;
    logic              load_d;
    logic              i_req;
    logic              d_req;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [BE_W-1:0]   be_q;
    logic              we_q;

    assign i_req = bus.i_read;
    assign d_req = bus.d_read | bus.d_write;

    // On completion only the other side may be granted, since the
    // finishing requester still holds its request this cycle.
    always_comb begin
        state_nxt  = state;
        last_d_nxt = last_d;
        load_i     = 1'b0;
        load_d     = 1'b0;
        unique case (state)
            IDLE: begin
                if (i_req && (!d_req || last_d)) load_i = 1'b1;
                else if (d_req)                  load_d = 1'b1;
            end
            GRANT_I: begin
                if (bus.mem_resp) begin
                    if (d_req) load_d    = 1'b1;
                    else       state_nxt = IDLE;
                end
            end
            GRANT_D: begin
                if (bus.mem_resp) begin
                    if (i_req) load_i    = 1'b1;
                    else       state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (load_i) begin
            state_nxt  = GRANT_I;
            last_d_nxt = 1'b0;
        end
        if (load_d) begin
            state_nxt  = GRANT_D;
            last_d_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            last_d  <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
        end else begin
            state  <= state_nxt;
            last_d <= last_d_nxt;
            if (load_i) begin
                addr_q  <= bus.i_address;
                wdata_q <= '0;
                be_q    <= '1;
                we_q    <= 1'b0;
            end else if (load_d) begin
                // read+write together is resolved as a write
                addr_q  <= bus.d_address;
                wdata_q <= bus.d_wdata;
                be_q    <= bus.d_write ? bus.d_byte_enable : '1;
                we_q    <= bus.d_write;
            end
        end
    end

    assign bus.mem_read        = (state == GRANT_I) ||
                                 ((state == GRANT_D) && !we_q);
    assign bus.mem_write       = (state == GRANT_D) && we_q;
    assign bus.mem_address     = addr_q;
    assign bus.mem_wdata       = wdata_q;
    assign bus.mem_byte_enable = be_q;

    assign bus.i_resp  = (state == GRANT_I) && bus.mem_resp;
    assign bus.d_resp  = (state == GRANT_D) && bus.mem_resp;
    assign bus.i_rdata = bus.mem_rdata;
    assign bus.d_rdata = bus.mem_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter.
// Expected responses are queued at request time and popped on resp.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mem_port_arbiter_if bus ();

    mem_port_arbiter dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        bit          d_side;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int tests = 0;
    int fails = 0;

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit d, input logic [31:0] a,
                        input logic [31:0] data);
        exp_t e;
        e.d_side = d;
        e.addr   = a;
        e.data   = data;
        exp_q.push_back(e);
    endtask

    // Memory model: waits for a strobe, answers one cycle later.
    task automatic serve_one(output bit d_side, output int waited);
        int n;
        exp_t e;
        logic [31:0] a;
        n = 0;
        d_side = 1'b0;
        waited = 0;
        @(negedge clk);
        while (!(bus.mem_read || bus.mem_write) && n < 30) begin
            @(negedge clk);
            n++;
        end
        waited = n;
        tests++;
        if (n >= 30) begin
            fails++;
            $display("FAIL serve_timeout: no strobe after %0d cycles", n);
            return;
        end
        tests++;
        if (bus.mem_read && bus.mem_write) begin
            fails++;
            $display("FAIL strobe_excl: read=1 write=1, need one");
        end
        a = bus.mem_address;
        step();
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = mem_model(a);
        @(negedge clk);
        d_side = bus.d_resp;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL sb_empty: resp with no expected entry");
        end else begin
            e = exp_q.pop_front();
            if ({bus.i_resp, bus.d_resp} !== (e.d_side ? 2'b01 : 2'b10)) begin
                fails++;
                $display("FAIL sb_resp: i/d resp %b%b, need d_side=%0d",
                         bus.i_resp, bus.d_resp, e.d_side);
            end
            tests++;
            if (a !== e.addr) begin
                fails++;
                $display("FAIL sb_addr: got %h need %h", a, e.addr);
            end
            tests++;
            if ((e.d_side ? bus.d_rdata : bus.i_rdata) !== e.data) begin
                fails++;
                $display("FAIL sb_rdata: got %h need %h",
                         e.d_side ? bus.d_rdata : bus.i_rdata, e.data);
            end
        end
        step();
        bus.mem_resp = 1'b0;
        if (d_side) begin
            bus.d_read  = 1'b0;
            bus.d_write = 1'b0;
        end else begin
            bus.i_read = 1'b0;
        end
    endtask

    task automatic do_reset();
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.i_read  = 1'b1;
        bus.d_write = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            @(negedge clk);
            tests++;
            if ({bus.mem_read, bus.mem_write, bus.i_resp, bus.d_resp} !== 4'b0) begin
                fails++;
                $display("FAIL reset_strobes: rd/wr/ir/dr=%b%b%b%b need 0000",
                         bus.mem_read, bus.mem_write, bus.i_resp, bus.d_resp);
            end
            tests++;
            if (bus.mem_address !== 32'h0 || bus.mem_byte_enable !== 4'h0 ||
                bus.mem_wdata !== 32'h0) begin
                fails++;
                $display("FAIL reset_fields: addr=%h be=%h wdata=%h need 0",
                         bus.mem_address, bus.mem_byte_enable, bus.mem_wdata);
            end
        end
        step();
        bus.i_read  = 1'b0;
        bus.d_write = 1'b0;
        rst = 1'b1;
        step();
        bus.mem_resp = 1'b1;
        @(negedge clk);
        tests++;
        if ({bus.i_resp, bus.d_resp, bus.mem_read} !== 3'b0) begin
            fails++;
            $display("FAIL idle_resp: ir/dr/rd=%b%b%b need 000",
                     bus.i_resp, bus.d_resp, bus.mem_read);
        end
        step();
        bus.mem_resp = 1'b0;
    endtask

    task automatic test_i_fetch();
        exp_t e;
        step();
        bus.i_address = 32'h60;
        bus.i_read    = 1'b1;
        push(1'b0, 32'h60, 32'hDEADBEEF);
        step();
        @(negedge clk);
        tests++;
        if (bus.mem_read !== 1'b1 || bus.mem_write !== 1'b0 ||
            bus.mem_address !== 32'h60 || bus.mem_byte_enable !== 4'hF) begin
            fails++;
            $display("FAIL fetch_grant: rd=%b wr=%b addr=%h be=%h need 1 0 60 f",
                     bus.mem_read, bus.mem_write, bus.mem_address,
                     bus.mem_byte_enable);
        end
        step();
        step();
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        tests++;
        if (bus.i_resp !== 1'b1 || bus.d_resp !== 1'b0) begin
            fails++;
            $display("FAIL fetch_resp: ir=%b dr=%b need 1 0",
                     bus.i_resp, bus.d_resp);
        end
        tests++;
        e = exp_q.pop_front();
        if (bus.i_rdata !== e.data) begin
            fails++;
            $display("FAIL fetch_rdata: got %h need %h", bus.i_rdata, e.data);
        end
        step();
        bus.mem_resp = 1'b0;
        bus.i_read   = 1'b0;
        @(negedge clk);
        tests++;
        if (bus.mem_read !== 1'b0 || bus.i_resp !== 1'b0) begin
            fails++;
            $display("FAIL fetch_done: rd=%b ir=%b need 0 0",
                     bus.mem_read, bus.i_resp);
        end
    endtask

    task automatic test_tie();
        bit s;
        int w1;
        int w2;
        do_reset();
        bus.i_address = 32'h300;
        bus.i_read    = 1'b1;
        bus.d_address = 32'h400;
        bus.d_read    = 1'b1;
        push(1'b0, 32'h300, mem_model(32'h300));
        push(1'b1, 32'h400, mem_model(32'h400));
        serve_one(s, w1);
        serve_one(s, w2);
        tests++;
        if (w2 !== 0) begin
            fails++;
            $display("FAIL tie_bubble: %0d idle cycles before D, need 0", w2);
        end
    endtask

    task automatic test_fairness();
        bit s;
        int w;
        int ni;
        int nd;
        ni = 0;
        nd = 0;
        do_reset();
        for (int k = 0; k < 8; k++)
            push(k % 2 == 1, (k % 2 == 1 ? 32'h2000 : 32'h1000) + 4 * (k / 2),
                 mem_model((k % 2 == 1 ? 32'h2000 : 32'h1000) + 4 * (k / 2)));
        bus.i_address = 32'h1000;
        bus.i_read    = 1'b1;
        bus.d_address = 32'h2000;
        bus.d_read    = 1'b1;
        for (int k = 0; k < 8; k++) begin
            serve_one(s, w);
            tests++;
            if (s !== (k % 2 == 1)) begin
                fails++;
                $display("FAIL fair_order: txn %0d d_side=%0d need %0d",
                         k, s, k % 2);
            end
            step();
            if (!s) begin
                ni++;
                if (ni < 4) begin
                    bus.i_address = 32'h1000 + 4 * ni;
                    bus.i_read    = 1'b1;
                end
            end else begin
                nd++;
                if (nd < 4) begin
                    bus.d_address = 32'h2000 + 4 * nd;
                    bus.d_read    = 1'b1;
                end
            end
        end
    endtask

    task automatic test_d_write();
        bit s;
        int w;
        step();
        bus.d_address     = 32'h104;
        bus.d_wdata       = 32'h1234;
        bus.d_byte_enable = 4'b0011;
        bus.d_write       = 1'b1;
        push(1'b1, 32'h104, mem_model(32'h104));
        step();
        @(negedge clk);
        tests++;
        if (bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0 ||
            bus.mem_address !== 32'h104 || bus.mem_wdata !== 32'h1234 ||
            bus.mem_byte_enable !== 4'b0011) begin
            fails++;
            $display("FAIL dwrite_grant: wr=%b rd=%b addr=%h wd=%h be=%b",
                     bus.mem_write, bus.mem_read, bus.mem_address,
                     bus.mem_wdata, bus.mem_byte_enable);
        end
        step();
        bus.d_address     = 32'h200;
        bus.d_wdata       = 32'hFFFF;
        bus.d_byte_enable = 4'hF;
        @(negedge clk);
        tests++;
        if (bus.mem_address !== 32'h104 || bus.mem_wdata !== 32'h1234 ||
            bus.mem_byte_enable !== 4'b0011) begin
            fails++;
            $display("FAIL dwrite_latch: addr=%h wd=%h be=%b need 104 1234 0011",
                     bus.mem_address, bus.mem_wdata, bus.mem_byte_enable);
        end
        serve_one(s, w);
        bus.d_address = 32'h108;
        bus.d_read    = 1'b1;
        bus.d_write   = 1'b1;
        push(1'b1, 32'h108, mem_model(32'h108));
        step();
        @(negedge clk);
        tests++;
        if (bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0) begin
            fails++;
            $display("FAIL rw_conflict: wr=%b rd=%b need 1 0",
                     bus.mem_write, bus.mem_read);
        end
        serve_one(s, w);
    endtask

    task automatic test_reset_mid();
        step();
        bus.i_address = 32'h500;
        bus.i_read    = 1'b1;
        step();
        @(negedge clk);
        tests++;
        if (bus.mem_read !== 1'b1) begin
            fails++;
            $display("FAIL mid_grant: rd=%b need 1", bus.mem_read);
        end
        step();
        rst = 1'b0;
        step();
        @(negedge clk);
        tests++;
        if (bus.mem_read !== 1'b0 || bus.mem_address !== 32'h0) begin
            fails++;
            $display("FAIL mid_reset: rd=%b addr=%h need 0 0",
                     bus.mem_read, bus.mem_address);
        end
        step();
        rst = 1'b1;
        bus.i_read = 1'b0;
        step();
        bus.mem_resp = 1'b1;
        @(negedge clk);
        tests++;
        if (bus.i_resp !== 1'b0 || bus.d_resp !== 1'b0) begin
            fails++;
            $display("FAIL stale_resp: ir=%b dr=%b need 0 0",
                     bus.i_resp, bus.d_resp);
        end
        step();
        bus.mem_resp = 1'b0;
    endtask

    initial begin
        rst                = 1'b0;
        bus.i_read         = 1'b0;
        bus.i_address      = '0;
        bus.d_read         = 1'b0;
        bus.d_write        = 1'b0;
        bus.d_byte_enable  = '0;
        bus.d_address      = '0;
        bus.d_wdata        = '0;
        bus.mem_rdata      = '0;
        bus.mem_resp       = 1'b0;
        test_reset();
        test_i_fetch();
        test_tie();
        test_fairness();
        test_d_write();
        test_reset_mid();
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL sb_leftover: %0d entries unserved, need 0",
                     exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
